// File: rtl/frv_mem_arbiter.sv
// Two-to-one arbiter sharing one split-transaction memory port between the
// instruction (imem) and data (dmem) interfaces. Grant order is kept in a small
// ID FIFO so responses are routed back in order. A starvation counter gives
// imem priority once it has been blocked by dmem for too long.
module frv_mem_arbiter #(
   parameter int unsigned OUTSTANDING  = 2,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        g_clk,
   input  logic        g_resetn,

   input  logic        imem_req,
   input  logic        imem_wen,
   input  logic [3:0]  imem_strb,
   input  logic [31:0] imem_wdata,
   input  logic [31:0] imem_addr,
   output logic        imem_gnt,
   output logic        imem_recv,
   input  logic        imem_ack,
   output logic        imem_error,
   output logic [31:0] imem_rdata,

   input  logic        dmem_req,
   input  logic        dmem_wen,
   input  logic [3:0]  dmem_strb,
   input  logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_addr,
   output logic        dmem_gnt,
   output logic        dmem_recv,
   input  logic        dmem_ack,
   output logic        dmem_error,
   output logic [31:0] dmem_rdata,

   output logic        mem_req,
   output logic        mem_wen,
   output logic [3:0]  mem_strb,
   output logic [31:0] mem_wdata,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_recv,
   output logic        mem_ack,
   input  logic        mem_error,
   input  logic [31:0] mem_rdata,

   output logic        arb_err
);

   // Storage is sized for the largest legal depth; pointers wrap at OUTSTANDING.
   localparam logic [2:0] FullCnt   = 3'(OUTSTANDING);
   localparam logic [1:0] LastPtr   = 2'(OUTSTANDING - 1);
   localparam logic [7:0] StarveLim = 8'(STARVE_LIMIT);

   logic [3:0] fifo_q, fifo_d;
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [2:0] count_q, count_d;
   logic       lock_q, lock_d;
   logic       lock_id_q, lock_id_d;
   logic [7:0] starve_q, starve_d;
   logic       arb_err_q, arb_err_d;

   logic full, has_out, head, sel, sel_req, push, pop, head_ack, stray;

   assign full    = (count_q == FullCnt);
   assign has_out = (count_q != 3'd0);
   assign head    = fifo_q[rd_ptr_q];

   // Requester selection: held lock, then starved imem, then dmem, else imem (0 = imem).
   always_comb begin
      sel = 1'b0;
      if (lock_q) begin
         sel = lock_id_q;
      end else if ((starve_q >= StarveLim) && imem_req) begin
         sel = 1'b0;
      end else begin
         sel = dmem_req;
      end
   end

   assign sel_req   = sel ? dmem_req : imem_req;
   assign mem_req   = sel_req & ~full & g_resetn;
   assign mem_wen   = sel ? dmem_wen   : imem_wen;
   assign mem_strb  = sel ? dmem_strb  : imem_strb;
   assign mem_wdata = sel ? dmem_wdata : imem_wdata;
   assign mem_addr  = sel ? dmem_addr  : imem_addr;

   assign push     = mem_req & mem_gnt;
   assign imem_gnt = push & ~sel;
   assign dmem_gnt = push & sel;

   // Responses go to the FIFO head; with nothing outstanding they are acked and dropped.
   assign head_ack   = head ? dmem_ack : imem_ack;
   assign mem_ack    = g_resetn & (has_out ? head_ack : mem_recv);
   assign imem_recv  = g_resetn & mem_recv & has_out & ~head;
   assign dmem_recv  = g_resetn & mem_recv & has_out & head;
   assign imem_rdata = mem_rdata;
   assign dmem_rdata = mem_rdata;
   assign imem_error = mem_error;
   assign dmem_error = mem_error;

   assign pop   = mem_recv & mem_ack & has_out;
   assign stray = mem_recv & ~has_out & g_resetn;

   assign arb_err = arb_err_q;

   // Next-state for ID FIFO, request lock, starvation counter and error flag.
   always_comb begin
      fifo_d    = fifo_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      starve_d  = 8'd0;
      arb_err_d = arb_err_q | stray;

      if (push) begin
         fifo_d[wr_ptr_q] = sel;
         wr_ptr_d         = (wr_ptr_q == LastPtr) ? 2'd0 : wr_ptr_q + 2'd1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LastPtr) ? 2'd0 : rd_ptr_q + 2'd1;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase

      // Hold the presented requester until the memory accepts it.
      if (mem_req) begin
         if (mem_gnt) begin
            lock_d = 1'b0;
         end else begin
            lock_d    = 1'b1;
            lock_id_d = sel;
         end
      end

      if (imem_req && !imem_gnt) begin
         starve_d = (starve_q == 8'hff) ? starve_q : starve_q + 8'd1;
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         fifo_q    <= 4'd0;
         wr_ptr_q  <= 2'd0;
         rd_ptr_q  <= 2'd0;
         count_q   <= 3'd0;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
         starve_q  <= 8'd0;
         arb_err_q <= 1'b0;
      end else begin
         fifo_q    <= fifo_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         starve_q  <= starve_d;
         arb_err_q <= arb_err_d;
      end
   end

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Self-checking bench for frv_mem_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model (queue of
// outstanding owners, pending-request lock, starvation cycle count).
module tb_frv_mem_arbiter;

   localparam int unsigned OUTS = 2;
   localparam int unsigned LIM  = 8;

   logic        g_clk, g_resetn;
   logic        imem_req, imem_wen, imem_ack;
   logic [3:0]  imem_strb;
   logic [31:0] imem_wdata, imem_addr;
   logic        imem_gnt, imem_recv, imem_error;
   logic [31:0] imem_rdata;
   logic        dmem_req, dmem_wen, dmem_ack;
   logic [3:0]  dmem_strb;
   logic [31:0] dmem_wdata, dmem_addr;
   logic        dmem_gnt, dmem_recv, dmem_error;
   logic [31:0] dmem_rdata;
   logic        mem_req, mem_wen, mem_gnt, mem_recv, mem_ack, mem_error;
   logic [3:0]  mem_strb;
   logic [31:0] mem_wdata, mem_addr, mem_rdata;
   logic        arb_err;

   frv_mem_arbiter #(.OUTSTANDING(OUTS), .STARVE_LIMIT(LIM)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .imem_req(imem_req), .imem_wen(imem_wen), .imem_strb(imem_strb),
      .imem_wdata(imem_wdata), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_error(imem_error),
      .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
      .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt),
      .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
      .dmem_rdata(dmem_rdata),
      .mem_req(mem_req), .mem_wen(mem_wen), .mem_strb(mem_strb),
      .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_recv(mem_recv), .mem_ack(mem_ack), .mem_error(mem_error),
      .mem_rdata(mem_rdata), .arb_err(arb_err)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state: owners of outstanding grants (0 = imem, 1 = dmem).
   bit idq[$];
   bit m_lock, m_lock_id, m_err;
   int m_starve;

   task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      idq.delete();
      m_lock    = 1'b0;
      m_lock_id = 1'b0;
      m_err     = 1'b0;
      m_starve  = 0;
   endtask

   task automatic idle_inputs();
      imem_req = 0; imem_wen = 0; imem_strb = 4'hf; imem_wdata = 0; imem_addr = 0;
      imem_ack = 0;
      dmem_req = 0; dmem_wen = 0; dmem_strb = 4'hf; dmem_wdata = 0; dmem_addr = 0;
      dmem_ack = 0;
      mem_gnt = 0; mem_recv = 0; mem_error = 0; mem_rdata = 0;
   endtask

   // Check one cycle against the model, then advance the model at the clock edge.
   // Called at a falling edge with inputs already applied.
   task automatic cycle();
      bit full, has, head, sel, e_req, e_ig, e_dg, e_ir, e_dr, e_ack;
      logic [68:0] e_bus;
      #1;
      full = (idq.size() == OUTS);
      has  = (idq.size() > 0);
      head = has ? idq[0] : 1'b0;
      if (m_lock)                                   sel = m_lock_id;
      else if (m_starve >= int'(LIM) && imem_req)   sel = 1'b0;
      else                                          sel = dmem_req;
      e_req = (sel ? dmem_req : imem_req) && !full && g_resetn;
      e_ig  = e_req && mem_gnt && !sel;
      e_dg  = e_req && mem_gnt && sel;
      e_ir  = g_resetn && mem_recv && has && !head;
      e_dr  = g_resetn && mem_recv && has && head;
      e_ack = has ? (head ? dmem_ack : imem_ack) : 1'b1;
      e_bus = sel ? {dmem_wen, dmem_strb, dmem_wdata, dmem_addr}
                  : {imem_wen, imem_strb, imem_wdata, imem_addr};
      chk_eq("mem_req", mem_req, e_req);
      chk_eq("imem_gnt", imem_gnt, e_ig);
      chk_eq("dmem_gnt", dmem_gnt, e_dg);
      chk_eq("imem_recv", imem_recv, e_ir);
      chk_eq("dmem_recv", dmem_recv, e_dr);
      if (e_req) chk_eq("mem_bus", {mem_wen, mem_strb, mem_wdata, mem_addr}, e_bus);
      if (!g_resetn) chk_eq("mem_ack_rst", mem_ack, 1'b0);
      else if (mem_recv) chk_eq("mem_ack", mem_ack, e_ack);
      chk_eq("resp_bcast", {imem_error, imem_rdata, dmem_error, dmem_rdata},
             {mem_error, mem_rdata, mem_error, mem_rdata});
      chk_eq("arb_err", arb_err, m_err);
      @(posedge g_clk);
      if (g_resetn) begin
         if (mem_recv && has && e_ack) void'(idq.pop_front());
         if (mem_recv && !has) m_err = 1'b1;
         if (e_req && mem_gnt) idq.push_back(sel);
         if (e_req && !mem_gnt) begin
            m_lock    = 1'b1;
            m_lock_id = sel;
         end else if (e_req) begin
            m_lock = 1'b0;
         end
         if (imem_req && !e_ig) m_starve = (m_starve < 255) ? m_starve + 1 : 255;
         else                   m_starve = 0;
      end
      @(negedge g_clk);
   endtask

   // Return every outstanding response, bounded, then leave one idle cycle.
   task automatic drain();
      idle_inputs();
      imem_ack = 1; dmem_ack = 1;
      for (int i = 0; i < 8 && idq.size() > 0; i++) begin
         mem_recv = 1;
         cycle();
      end
      if (idq.size() != 0) begin
         n_chk++; n_fail++;
         $display("FAIL drain: %0d still outstanding, expected 0", idq.size());
      end
      idle_inputs();
      cycle();
   endtask

   initial begin
      model_reset();
      idle_inputs();
      g_resetn = 0;
      imem_req = 1; dmem_req = 1; mem_gnt = 1; mem_recv = 1; imem_ack = 1;
      #3;
      chk_eq("rst_mem_req", mem_req, 1'b0);
      chk_eq("rst_mem_ack", mem_ack, 1'b0);
      chk_eq("rst_gnts", {imem_gnt, dmem_gnt}, 2'b00);
      chk_eq("rst_recvs", {imem_recv, dmem_recv}, 2'b00);
      chk_eq("rst_arb_err", arb_err, 1'b0);
      @(negedge g_clk);
      g_resetn = 1;
      idle_inputs();
      cycle();

      // Independent streams: imem reads then dmem writes.
      for (int i = 0; i < 2; i++) begin
         idle_inputs();
         imem_req = 1; imem_addr = 32'h8000_0000; mem_gnt = 1;
         #1;
         chk_eq("is_iaddr", mem_addr, 32'h8000_0000);
         chk_eq("is_iwen", mem_wen, 1'b0);
         chk_eq("is_igrant", imem_gnt, 1'b1);
         cycle();
      end
      for (int i = 0; i < 2; i++) begin
         idle_inputs();
         mem_recv = 1; mem_rdata = 32'hDEAD_BEEF; imem_ack = 1;
         #1;
         chk_eq("is_irecv", {imem_recv, dmem_recv}, 2'b10);
         chk_eq("is_irdata", imem_rdata, 32'hDEAD_BEEF);
         cycle();
      end
      for (int i = 0; i < 2; i++) begin
         idle_inputs();
         dmem_req = 1; dmem_wen = 1; dmem_addr = 32'h1000; dmem_wdata = 32'h55 + i;
         mem_gnt = 1;
         #1;
         chk_eq("is_daddr", mem_addr, 32'h1000);
         chk_eq("is_dwen", mem_wen, 1'b1);
         chk_eq("is_dgrant", dmem_gnt, 1'b1);
         cycle();
      end
      for (int i = 0; i < 2; i++) begin
         idle_inputs();
         mem_recv = 1; dmem_ack = 1;
         #1;
         chk_eq("is_drecv", {imem_recv, dmem_recv}, 2'b01);
         cycle();
      end
      drain();

      // Contention: dmem wins 8 cycles, imem the 9th, then dmem again.
      for (int k = 0; k < 10; k++) begin
         idle_inputs();
         imem_req = 1; imem_addr = 32'h100 + k; dmem_req = 1; dmem_addr = 32'h200 + k;
         mem_gnt = 1; imem_ack = 1; dmem_ack = 1;
         mem_recv = (idq.size() > 0);
         #1;
         chk_eq("cont_igrant", imem_gnt, (k == 8));
         chk_eq("cont_dgrant", dmem_gnt, (k != 8));
         cycle();
      end
      drain();

      // Lock: imem held while stalled, dmem waits.
      for (int k = 0; k < 5; k++) begin
         idle_inputs();
         imem_req = (k < 4); imem_addr = 32'hA000;
         dmem_req = (k >= 1); dmem_addr = 32'hB000;
         mem_gnt = (k >= 3);
         #1;
         if (k < 4) chk_eq("lock_addr", mem_addr, 32'hA000);
         chk_eq("lock_igrant", imem_gnt, (k == 3));
         chk_eq("lock_dgrant", dmem_gnt, (k == 4));
         cycle();
      end
      drain();

      // Full and ordering with two outstanding.
      idle_inputs(); dmem_req = 1; mem_gnt = 1; cycle();
      idle_inputs(); imem_req = 1; mem_gnt = 1; cycle();
      idle_inputs(); imem_req = 1; dmem_req = 1; mem_gnt = 1;
      #1; chk_eq("full_block", mem_req, 1'b0);
      cycle();
      idle_inputs(); imem_req = 1; dmem_req = 1; mem_gnt = 1; mem_recv = 1; dmem_ack = 1;
      #1;
      chk_eq("ord_first", {imem_recv, dmem_recv}, 2'b01);
      chk_eq("full_pop_same", mem_req, 1'b0);
      cycle();
      idle_inputs(); imem_req = 1; dmem_req = 1; mem_gnt = 1; mem_recv = 1; imem_ack = 1;
      #1;
      chk_eq("ord_second", {imem_recv, dmem_recv}, 2'b10);
      chk_eq("full_lift", mem_req, 1'b1);
      cycle();
      drain();

      // Stray response, then asynchronous reset with a transaction outstanding.
      idle_inputs(); mem_recv = 1;
      #1;
      chk_eq("stray_ack", mem_ack, 1'b1);
      chk_eq("stray_recv", {imem_recv, dmem_recv}, 2'b00);
      cycle();
      idle_inputs();
      #1; chk_eq("stray_err", arb_err, 1'b1);
      cycle();
      idle_inputs(); imem_req = 1; mem_gnt = 1; cycle();
      idle_inputs(); dmem_req = 1; mem_gnt = 0; cycle();
      idle_inputs(); imem_req = 1; mem_gnt = 1; mem_recv = 1; imem_ack = 1; dmem_ack = 1;
      #2;
      g_resetn = 0;
      model_reset();
      #1;
      chk_eq("arst_err", arb_err, 1'b0);
      chk_eq("arst_hs", {mem_req, mem_ack, imem_gnt, dmem_gnt, imem_recv, dmem_recv}, 6'd0);
      cycle();
      cycle();
      g_resetn = 1;
      idle_inputs(); imem_req = 1; imem_addr = 32'hC000; mem_gnt = 1;
      #1;
      chk_eq("post_rst_req", mem_req, 1'b1);
      chk_eq("post_rst_igrant", imem_gnt, 1'b1);
      cycle();
      idle_inputs(); mem_recv = 1; imem_ack = 1; cycle();
      drain();

      // Random traffic.
      for (int n = 0; n < 800; n++) begin
         imem_req   = ($urandom_range(0, 3) != 0);
         imem_wen   = $urandom_range(0, 1);
         imem_strb  = 4'($urandom);
         imem_wdata = $urandom;
         imem_addr  = $urandom;
         imem_ack   = ($urandom_range(0, 3) != 0);
         dmem_req   = ($urandom_range(0, 2) != 0);
         dmem_wen   = $urandom_range(0, 1);
         dmem_strb  = 4'($urandom);
         dmem_wdata = $urandom;
         dmem_addr  = $urandom;
         dmem_ack   = ($urandom_range(0, 3) != 0);
         mem_gnt    = ($urandom_range(0, 3) != 0);
         mem_recv   = (idq.size() > 0) ? ($urandom_range(0, 1) == 1)
                                       : ($urandom_range(0, 30) == 0);
         mem_error  = $urandom_range(0, 1);
         mem_rdata  = $urandom;
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
